// File: rtl/if_fetch.sv
// IF stage: single-entry instruction buffer between the I-memory port and if_id.
// Keeps an issued request stable until ack, and steers on branch/flush.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_ack_i,
  input  logic [31:0] inst_rdata_i,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_from_if
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_FULL,
    S_DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] fetch_q, fetch_d;
  logic        redir_q, redir_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] drain_pc_q, drain_pc_d;

  logic        consume;
  logic        br_take;
  logic        acked;
  logic [31:0] seq_pc;

  logic        unused_stall;
  assign unused_stall = ^{stall[5:3], stall[0]};

  assign consume = valid_q & ~stall[1];
  assign br_take = branch_flag_i & ~stall[2];
  assign acked   = inst_req_o & inst_ack_i;
  assign seq_pc  = fetch_q + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      valid_q    <= 1'b0;
      pc_q       <= 32'h0;
      inst_q     <= 32'h0;
      fetch_q    <= RESET_PC;
      redir_q    <= 1'b0;
      tgt_q      <= 32'h0;
      drain_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      fetch_q    <= fetch_d;
      redir_q    <= redir_d;
      tgt_q      <= tgt_d;
      drain_pc_q <= drain_pc_d;
    end
  end

  always_comb begin
    inst_req_o = 1'b0;
    inst_addr_o = fetch_q;
    unique case (state_q)
      S_FETCH,
      S_DRAIN: inst_req_o = 1'b1;
      S_FULL:  inst_req_o = ~stall[1] & ~flush & ~branch_flag_i;
      default: inst_req_o = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    fetch_d    = fetch_q;
    redir_d    = redir_q;
    tgt_d      = tgt_q;
    drain_pc_d = drain_pc_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        fetch_d = flush ? new_pc : RESET_PC;
      end
      S_FETCH: begin
        if (flush) begin
          redir_d = 1'b0;
          valid_d = 1'b0;
          if (acked) begin
            fetch_d = new_pc;
          end else begin
            drain_pc_d = new_pc;
            state_d    = S_DRAIN;
          end
        end else if (acked) begin
          valid_d = 1'b1;
          pc_d    = fetch_q;
          inst_d  = inst_rdata_i;
          redir_d = 1'b0;
          state_d = S_FULL;
          if (br_take)
            fetch_d = branch_target_address_i;
          else if (redir_q)
            fetch_d = tgt_q;
          else
            fetch_d = seq_pc;
        end else if (br_take) begin
          // delay slot still in flight: remember where to go after it
          redir_d = 1'b1;
          tgt_d   = branch_target_address_i;
        end
      end
      S_FULL: begin
        if (flush) begin
          valid_d = 1'b0;
          redir_d = 1'b0;
          fetch_d = new_pc;
          state_d = S_FETCH;
        end else if (acked) begin
          pc_d    = fetch_q;
          inst_d  = inst_rdata_i;
          fetch_d = seq_pc;
        end else begin
          if (br_take)
            fetch_d = branch_target_address_i;
          if (consume) begin
            valid_d = 1'b0;
            state_d = S_FETCH;
          end
        end
      end
      S_DRAIN: begin
        if (flush)
          drain_pc_d = new_pc;
        if (acked) begin
          fetch_d = flush ? new_pc : drain_pc_q;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign if_pc            = valid_q ? pc_q : 32'h0;
  assign if_inst          = valid_q ? inst_q : 32'h0;
  assign stallreq_from_if = ~valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios plus randomized traffic
// against a buffer/in-flight level reference model.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_ack_i;
  logic [31:0] inst_rdata_i;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_from_if;

  int n_cmp;
  int n_bad;

  if_fetch #(.RESET_PC(32'h0)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .inst_req_o              (inst_req_o),
    .inst_addr_o             (inst_addr_o),
    .inst_ack_i              (inst_ack_i),
    .inst_rdata_i            (inst_rdata_i),
    .if_pc                   (if_pc),
    .if_inst                 (if_inst),
    .stallreq_from_if        (stallreq_from_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h0000_9E37) ^ 32'h5A5A_1234;
  endfunction

  assign inst_rdata_i = mem_f(inst_addr_o);

  // reference model: buffer contents, next address, in-flight discard
  bit          m_started;
  bit          m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_next;
  bit          m_redir;
  logic [31:0] m_rt;
  bit          m_drain;
  logic [31:0] m_if_addr;

  function automatic bit m_req();
    if (!m_started) return 1'b0;
    if (m_drain || !m_valid) return 1'b1;
    return !stall[1] && !flush && !branch_flag_i;
  endfunction

  function automatic logic [31:0] m_addr();
    return m_drain ? m_if_addr : m_next;
  endfunction

  task automatic model_step();
    bit rq, v0, cons, br, acked;
    logic [31:0] ad;
    rq = m_req();
    ad = m_addr();
    v0 = m_valid;
    cons = m_valid && !stall[1];
    br = branch_flag_i && !stall[2];
    acked = rq && inst_ack_i;
    if (rst) begin
      m_started = 0; m_valid = 0; m_redir = 0; m_drain = 0;
      m_next = 32'h0;
    end else if (!m_started) begin
      m_started = 1;
      if (flush) m_next = new_pc;
    end else if (m_drain) begin
      if (flush) m_next = new_pc;
      if (inst_ack_i) m_drain = 0;
    end else if (flush) begin
      if (rq && !inst_ack_i) begin
        m_drain = 1;
        m_if_addr = m_next;
      end
      m_valid = 0; m_redir = 0; m_next = new_pc;
    end else begin
      if (cons) m_valid = 0;
      if (acked) begin
        m_valid = 1; m_pc = ad; m_inst = mem_f(ad);
        m_next = br ? branch_target_address_i : (m_redir ? m_rt : ad + 32'd4);
        m_redir = 0;
      end else if (br) begin
        if (v0) m_next = branch_target_address_i;
        else begin
          m_redir = 1;
          m_rt = branch_target_address_i;
        end
      end
    end
  endtask

  task automatic drive(input logic r, input logic [5:0] st, input logic fl,
                       input logic [31:0] np, input logic bf,
                       input logic [31:0] bt, input logic ak);
    rst = r; stall = st; flush = fl; new_pc = np;
    branch_flag_i = bf; branch_target_address_i = bt; inst_ack_i = ak;
    #1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic boot(input logic fl, input logic [31:0] np);
    drive(1, 6'h0, 0, 32'h0, 0, 32'h0, 0);
    tick();
    drive(0, 6'h0, fl, np, 0, 32'h0, 0);
    tick();
  endtask

  task automatic test_reset();
    drive(1, 6'h0, 0, 32'h0, 0, 32'h0, 1);
    tick();
    n_cmp += 4;
    if (inst_req_o !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b exp 0", inst_req_o); end
    if (if_pc !== 32'h0) begin n_bad++; $display("FAIL rst_pc got %h exp 0", if_pc); end
    if (if_inst !== 32'h0) begin n_bad++; $display("FAIL rst_inst got %h exp 0", if_inst); end
    if (stallreq_from_if !== 1'b1) begin n_bad++; $display("FAIL rst_stallreq got %b exp 1", stallreq_from_if); end
  endtask

  task automatic test_seq();
    boot(0, 32'h0);
    drive(0, 6'h0, 0, 32'h0, 0, 32'h0, 1);
    n_cmp += 2;
    if (inst_req_o !== 1'b1) begin n_bad++; $display("FAIL seq_req0 got %b exp 1", inst_req_o); end
    if (inst_addr_o !== 32'h0) begin n_bad++; $display("FAIL seq_addr0 got %h exp 0", inst_addr_o); end
    tick();
    n_cmp += 3;
    if (inst_addr_o !== 32'h4) begin n_bad++; $display("FAIL seq_addr4 got %h exp 4", inst_addr_o); end
    if (if_pc !== 32'h0) begin n_bad++; $display("FAIL seq_pc0 got %h exp 0", if_pc); end
    if (if_inst !== mem_f(32'h0)) begin n_bad++; $display("FAIL seq_inst0 got %h exp %h", if_inst, mem_f(32'h0)); end
    tick();
    n_cmp += 2;
    if (inst_addr_o !== 32'h8) begin n_bad++; $display("FAIL seq_addr8 got %h exp 8", inst_addr_o); end
    if (if_pc !== 32'h4) begin n_bad++; $display("FAIL seq_pc4 got %h exp 4", if_pc); end
    tick();
    n_cmp += 2;
    if (if_pc !== 32'h8) begin n_bad++; $display("FAIL seq_pc8 got %h exp 8", if_pc); end
    if (if_inst !== mem_f(32'h8)) begin n_bad++; $display("FAIL seq_inst8 got %h exp %h", if_inst, mem_f(32'h8)); end
  endtask

  task automatic test_ack_delay();
    boot(0, 32'h0);
    drive(0, 6'h0, 0, 32'h0, 0, 32'h0, 1);
    tick();
    drive(0, 6'h0, 0, 32'h0, 0, 32'h0, 0);
    n_cmp++;
    if (inst_addr_o !== 32'h4) begin n_bad++; $display("FAIL dly_addr_c got %h exp 4", inst_addr_o); end
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 6'h0, 0, 32'h0, 0, 32'h0, 0);
      n_cmp += 4;
      if (inst_req_o !== 1'b1) begin n_bad++; $display("FAIL dly_req got %b exp 1", inst_req_o); end
      if (inst_addr_o !== 32'h4) begin n_bad++; $display("FAIL dly_addr got %h exp 4", inst_addr_o); end
      if (stallreq_from_if !== 1'b1) begin n_bad++; $display("FAIL dly_stallreq got %b exp 1", stallreq_from_if); end
      if (if_inst !== 32'h0) begin n_bad++; $display("FAIL dly_inst got %h exp 0", if_inst); end
      tick();
    end
    drive(0, 6'h0, 0, 32'h0, 0, 32'h0, 1);
    n_cmp++;
    if (inst_addr_o !== 32'h4) begin n_bad++; $display("FAIL dly_addr_ack got %h exp 4", inst_addr_o); end
    tick();
    n_cmp += 2;
    if (if_pc !== 32'h4) begin n_bad++; $display("FAIL dly_pc got %h exp 4", if_pc); end
    if (stallreq_from_if !== 1'b0) begin n_bad++; $display("FAIL dly_fill got %b exp 0", stallreq_from_if); end
  endtask

  task automatic test_branch();
    boot(0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 6'h0, 0, 32'h0, 0, 32'h0, 1);
      tick();
    end
    drive(0, 6'h0, 0, 32'h0, 0, 32'h0, 0);
    n_cmp++;
    if (if_pc !== 32'h8) begin n_bad++; $display("FAIL br_pc8 got %h exp 8", if_pc); end
    tick();
    drive(0, 6'h0, 0, 32'h0, 1, 32'h100, 0);
    n_cmp++;
    if (inst_addr_o !== 32'hC) begin n_bad++; $display("FAIL br_slot_req got %h exp c", inst_addr_o); end
    tick();
    drive(0, 6'h0, 0, 32'h0, 0, 32'h0, 1);
    n_cmp++;
    if (inst_addr_o !== 32'hC) begin n_bad++; $display("FAIL br_slot_hold got %h exp c", inst_addr_o); end
    tick();
    n_cmp += 2;
    if (if_pc !== 32'hC) begin n_bad++; $display("FAIL br_slot_pc got %h exp c", if_pc); end
    if (inst_addr_o !== 32'h100) begin n_bad++; $display("FAIL br_target got %h exp 100", inst_addr_o); end
    tick();
    n_cmp += 2;
    if (if_pc !== 32'h100) begin n_bad++; $display("FAIL br_tpc got %h exp 100", if_pc); end
    if (inst_addr_o !== 32'h104) begin n_bad++; $display("FAIL br_next got %h exp 104", inst_addr_o); end
  endtask

  task automatic test_flush();
    boot(1, 32'h20);
    drive(0, 6'h0, 1, 32'h180, 0, 32'h0, 0);
    n_cmp++;
    if (inst_addr_o !== 32'h20) begin n_bad++; $display("FAIL fl_addr20 got %h exp 20", inst_addr_o); end
    tick();
    drive(0, 6'h0, 0, 32'h0, 1, 32'h300, 0);
    n_cmp += 2;
    if (inst_req_o !== 1'b1) begin n_bad++; $display("FAIL fl_drain_req got %b exp 1", inst_req_o); end
    if (inst_addr_o !== 32'h20) begin n_bad++; $display("FAIL fl_drain_addr got %h exp 20", inst_addr_o); end
    tick();
    drive(0, 6'h0, 0, 32'h0, 0, 32'h0, 1);
    n_cmp++;
    if (inst_addr_o !== 32'h20) begin n_bad++; $display("FAIL fl_drain_ack got %h exp 20", inst_addr_o); end
    tick();
    n_cmp += 3;
    if (inst_addr_o !== 32'h180) begin n_bad++; $display("FAIL fl_newpc got %h exp 180", inst_addr_o); end
    if (if_pc !== 32'h0) begin n_bad++; $display("FAIL fl_discard got %h exp 0", if_pc); end
    if (stallreq_from_if !== 1'b1) begin n_bad++; $display("FAIL fl_empty got %b exp 1", stallreq_from_if); end
    tick();
    n_cmp++;
    if (if_pc !== 32'h180) begin n_bad++; $display("FAIL fl_pc180 got %h exp 180", if_pc); end
  endtask

  task automatic test_stall();
    boot(0, 32'h0);
    drive(0, 6'h0, 0, 32'h0, 0, 32'h0, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 6'b000111, 0, 32'h0, 0, 32'h0, 1);
      n_cmp += 3;
      if (inst_req_o !== 1'b0) begin n_bad++; $display("FAIL st_req got %b exp 0", inst_req_o); end
      if (if_pc !== 32'h0) begin n_bad++; $display("FAIL st_pc got %h exp 0", if_pc); end
      if (if_inst !== mem_f(32'h0)) begin n_bad++; $display("FAIL st_inst got %h exp %h", if_inst, mem_f(32'h0)); end
      tick();
    end
    drive(0, 6'h0, 0, 32'h0, 0, 32'h0, 1);
    n_cmp++;
    if (inst_addr_o !== 32'h4) begin n_bad++; $display("FAIL st_resume got %h exp 4", inst_addr_o); end
    tick();
    n_cmp++;
    if (if_pc !== 32'h4) begin n_bad++; $display("FAIL st_pc4 got %h exp 4", if_pc); end
  endtask

  task automatic test_reset_mid();
    boot(1, 32'h40);
    drive(0, 6'h0, 0, 32'h0, 0, 32'h0, 0);
    n_cmp++;
    if (inst_addr_o !== 32'h40) begin n_bad++; $display("FAIL rm_addr40 got %h exp 40", inst_addr_o); end
    tick();
    drive(1, 6'h0, 0, 32'h0, 0, 32'h0, 1);
    tick();
    drive(0, 6'h0, 0, 32'h0, 0, 32'h0, 1);
    n_cmp += 3;
    if (inst_req_o !== 1'b0) begin n_bad++; $display("FAIL rm_req got %b exp 0", inst_req_o); end
    if (if_pc !== 32'h0) begin n_bad++; $display("FAIL rm_pc got %h exp 0", if_pc); end
    if (stallreq_from_if !== 1'b1) begin n_bad++; $display("FAIL rm_stallreq got %b exp 1", stallreq_from_if); end
    tick();
    n_cmp++;
    if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h0) begin
      n_bad++; $display("FAIL rm_first got %b/%h exp 1/0", inst_req_o, inst_addr_o);
    end
  endtask

  task automatic test_wrap();
    boot(1, 32'hFFFF_FFFC);
    drive(0, 6'h0, 0, 32'h0, 0, 32'h0, 1);
    n_cmp++;
    if (inst_addr_o !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wr_addr got %h exp fffffffc", inst_addr_o); end
    tick();
    n_cmp += 2;
    if (if_pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wr_pc got %h exp fffffffc", if_pc); end
    if (inst_addr_o !== 32'h0) begin n_bad++; $display("FAIL wr_wrap got %h exp 0", inst_addr_o); end
  endtask

  task automatic test_random();
    logic [31:0] r1, r2;
    logic [5:0] st;
    boot(0, 32'h0);
    for (int i = 0; i < 4000; i++) begin
      r1 = $urandom;
      r2 = $urandom;
      st = 6'h0;
      st[1] = ($urandom_range(0, 3) == 0);
      st[2] = ($urandom_range(0, 4) == 0);
      st[0] = r1[0];
      st[5] = r1[1];
      if (r1[2] && r1[3]) r2 = 32'hFFFF_FFF8;
      drive(($urandom_range(0, 199) == 0), st,
            ($urandom_range(0, 24) == 0), {r1[31:4], 4'h0},
            ($urandom_range(0, 7) == 0), {r2[31:2], 2'b00},
            ($urandom_range(0, 9) < 6));
      n_cmp += 4;
      if (inst_req_o !== m_req()) begin
        n_bad++; $display("FAIL rnd_req cyc %0d got %b exp %b", i, inst_req_o, m_req());
      end
      if (if_pc !== (m_valid ? m_pc : 32'h0)) begin
        n_bad++; $display("FAIL rnd_pc cyc %0d got %h exp %h", i, if_pc, m_valid ? m_pc : 32'h0);
      end
      if (if_inst !== (m_valid ? m_inst : 32'h0)) begin
        n_bad++; $display("FAIL rnd_inst cyc %0d got %h exp %h", i, if_inst, m_valid ? m_inst : 32'h0);
      end
      if (stallreq_from_if !== !m_valid) begin
        n_bad++; $display("FAIL rnd_stallreq cyc %0d got %b exp %b", i, stallreq_from_if, !m_valid);
      end
      if (m_req()) begin
        n_cmp++;
        if (inst_addr_o !== m_addr()) begin
          n_bad++; $display("FAIL rnd_addr cyc %0d got %h exp %h", i, inst_addr_o, m_addr());
        end
      end
      tick();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_started = 0; m_valid = 0; m_redir = 0; m_drain = 0;
    m_next = 32'h0; m_pc = 32'h0; m_inst = 32'h0;
    m_rt = 32'h0; m_if_addr = 32'h0;
    rst = 1'b1; stall = 6'h0; flush = 1'b0; new_pc = 32'h0;
    branch_flag_i = 1'b0; branch_target_address_i = 32'h0; inst_ack_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_seq();
    test_ack_delay();
    test_branch();
    test_flush();
    test_stall();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
